// File: rtl/alu_result_framer_pkg.sv
// Shared types and constants for the ALU result framer: FSM states, byte width
// and the status byte layout.
package alu_frame_pkg;

  localparam int BYTE_W         = 8;
  localparam int STAT_CARRY_BIT = 0;
  localparam logic [BYTE_W-1:0] STAT_BYTE_BASE = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STAT = 2'd2
  } frame_state_e;

  function automatic logic [BYTE_W-1:0] status_byte(input logic carry);
    logic [BYTE_W-1:0] b;
    b                 = STAT_BYTE_BASE;
    b[STAT_CARRY_BIT] = carry;
    return b;
  endfunction

endpackage

// File: rtl/alu_result_framer_if.sv
// Byte-wide TX stream with valid/ready handshake between the framer and its consumer.
interface alu_result_framer_if;
  import alu_frame_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/alu_result_framer.sv
// Captures an ALU result on each rising edge of res_valid and streams it out
// LSB byte first, optionally followed by a carry status byte.
module alu_result_framer
  import alu_frame_pkg::*;
#(
  parameter int RES_WIDTH   = 32,
  parameter bit SEND_STATUS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RES_WIDTH-1:0] res_data,
  input  logic                 res_carry,
  input  logic                 res_valid,
  input  logic                 clr_ovr,
  alu_result_framer_if.master  tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int NBYTES = RES_WIDTH / BYTE_W;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  frame_state_e        state_r, next_state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s, next_idx_s;
  logic [RES_WIDTH-1:0] capture_r, capture_s;
  logic                carry_r, carry_s;
  logic                valid_q_r;
  logic [BYTE_W-1:0]   tx_data_r, tx_data_s;
  logic                tx_valid_r, tx_valid_s;
  logic                frame_done_r, frame_done_s;
  logic                overrun_r, overrun_s;
  logic                busy_r;
  logic                rise_s, xfer_s, last_s;

  assign rise_s     = res_valid & ~valid_q_r;
  assign xfer_s     = tx_valid_r & tx.tx_ready;
  assign last_s     = (cnt_r == LAST_IDX);
  assign next_idx_s = cnt_r + CNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (rise_s) next_state_s = DATA;
        else        next_state_s = IDLE;
      end
      DATA: begin
        if (xfer_s && last_s) next_state_s = SEND_STATUS ? STAT : IDLE;
        else                  next_state_s = DATA;
      end
      STAT: begin
        if (xfer_s) next_state_s = IDLE;
        else        next_state_s = STAT;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Next values for the datapath and registered outputs
  always_comb begin
    tx_data_s    = tx_data_r;
    tx_valid_s   = tx_valid_r;
    frame_done_s = 1'b0;
    cnt_s        = cnt_r;
    capture_s    = capture_r;
    carry_s      = carry_r;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          capture_s  = res_data;
          carry_s    = res_carry;
          tx_data_s  = res_data[BYTE_W-1:0];
          tx_valid_s = 1'b1;
          cnt_s      = '0;
        end else begin
          tx_data_s  = '0;
          tx_valid_s = 1'b0;
        end
      end
      DATA: begin
        if (xfer_s && !last_s) begin
          cnt_s     = next_idx_s;
          tx_data_s = capture_r[next_idx_s*BYTE_W +: BYTE_W];
        end else if (xfer_s && SEND_STATUS) begin
          tx_data_s = status_byte(carry_r);
        end else if (xfer_s) begin
          tx_data_s    = '0;
          tx_valid_s   = 1'b0;
          frame_done_s = 1'b1;
        end else begin
          tx_data_s  = tx_data_r;
          tx_valid_s = tx_valid_r;
        end
      end
      STAT: begin
        if (xfer_s) begin
          tx_data_s    = '0;
          tx_valid_s   = 1'b0;
          frame_done_s = 1'b1;
        end else begin
          tx_data_s  = tx_data_r;
          tx_valid_s = tx_valid_r;
        end
      end
      default: begin
        tx_data_s  = '0;
        tx_valid_s = 1'b0;
      end
    endcase
  end

  // A rise outside IDLE drops the result; a new drop beats a same-cycle clear
  always_comb begin
    if (rise_s && (state_r != IDLE)) overrun_s = 1'b1;
    else if (clr_ovr)                overrun_s = 1'b0;
    else                             overrun_s = overrun_r;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_r    <= '0;
      tx_valid_r   <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
      cnt_r        <= '0;
      capture_r    <= '0;
      carry_r      <= 1'b0;
      valid_q_r    <= 1'b0;
    end else begin
      tx_data_r    <= tx_data_s;
      tx_valid_r   <= tx_valid_s;
      frame_done_r <= frame_done_s;
      overrun_r    <= overrun_s;
      busy_r       <= (next_state_s != IDLE);
      cnt_r        <= cnt_s;
      capture_r    <= capture_s;
      carry_r      <= carry_s;
      valid_q_r    <= res_valid;
    end
  end

  assign tx.tx_data  = tx_data_r;
  assign tx.tx_valid = tx_valid_r;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_alu_result_framer.sv
// Directed bench: a 32-bit framer with status byte and a 16-bit framer without.
module tb_alu_result_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] res_data;
  logic        res_carry, res_valid, clr_ovr;
  logic        busy, frame_done, overrun;
  logic [15:0] res_data_b;
  logic        res_carry_b, res_valid_b, clr_ovr_b;
  logic        busy_b, frame_done_b, overrun_b;

  int n_cmp = 0;
  int n_err = 0;

  alu_result_framer_if txa ();
  alu_result_framer_if txb ();

  alu_result_framer #(.RES_WIDTH(32), .SEND_STATUS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .res_data(res_data), .res_carry(res_carry),
    .res_valid(res_valid), .clr_ovr(clr_ovr), .tx(txa),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  alu_result_framer #(.RES_WIDTH(16), .SEND_STATUS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .res_data(res_data_b), .res_carry(res_carry_b),
    .res_valid(res_valid_b), .clr_ovr(clr_ovr_b), .tx(txb),
    .busy(busy_b), .frame_done(frame_done_b), .overrun(overrun_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_a [5];
    logic [7:0] exp_c [5];
    logic       pat [10];
    int         k, frames, xfers;
    logic       ovr_seen;

    exp_a = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h01};
    exp_c = '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h00};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; res_data = 32'h0; res_carry = 1'b0; res_valid = 1'b0; clr_ovr = 1'b0;
    res_data_b = 16'h0; res_carry_b = 1'b0; res_valid_b = 1'b0; clr_ovr_b = 1'b0;
    txa.tx_ready = 1'b1; txb.tx_ready = 1'b1;
    step(); step();
    chk("rst_tx_data", {24'h0, txa.tx_data}, 32'h0);
    chk("rst_tx_valid", {31'h0, txa.tx_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    chk("rst_b_tx_valid", {31'h0, txb.tx_valid}, 32'h0);
    rst = 1'b0;

    // Frame with tx_ready tied high: one byte per cycle
    res_data = 32'h11223344; res_carry = 1'b1; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    chk("t1_busy", {31'h0, busy}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_byte%0d", i), {24'h0, txa.tx_data}, {24'h0, exp_a[i]});
      chk($sformatf("t1_valid%0d", i), {31'h0, txa.tx_valid}, 32'h1);
      chk($sformatf("t1_fd%0d", i), {31'h0, frame_done}, 32'h0);
      step();
    end
    chk("t1_frame_done", {31'h0, frame_done}, 32'h1);
    chk("t1_valid_off", {31'h0, txa.tx_valid}, 32'h0);
    chk("t1_data_zero", {24'h0, txa.tx_data}, 32'h0);
    chk("t1_busy_off", {31'h0, busy}, 32'h0);
    step();
    chk("t1_fd_pulse", {31'h0, frame_done}, 32'h0);

    // Same frame with a stalling consumer
    txa.tx_ready = 1'b0; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      txa.tx_ready = pat[c];
      chk($sformatf("t2_valid_c%0d", c), {31'h0, txa.tx_valid}, 32'h1);
      chk($sformatf("t2_byte_c%0d", c), {24'h0, txa.tx_data}, {24'h0, exp_a[k]});
      step();
      if (pat[c]) k++;
    end
    chk("t2_frame_done", {31'h0, frame_done}, 32'h1);
    chk("t2_valid_off", {31'h0, txa.tx_valid}, 32'h0);
    txa.tx_ready = 1'b1;
    step();

    // res_valid held high for 20 cycles yields a single frame
    res_data = 32'hCAFEF00D; res_carry = 1'b0; res_valid = 1'b1;
    frames = 0; xfers = 0; ovr_seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (c < 5) chk($sformatf("t3_byte%0d", c), {24'h0, txa.tx_data}, {24'h0, exp_c[c]});
      if (c == 19) res_valid = 1'b0;
      if (txa.tx_valid && txa.tx_ready) xfers++;
      if (frame_done) frames++;
      ovr_seen = ovr_seen | overrun;
    end
    chk("t3_frames", frames, 32'd1);
    chk("t3_xfers", xfers, 32'd5);
    chk("t3_overrun", {31'h0, ovr_seen}, 32'h0);

    // Second rise mid-frame is dropped and flagged
    res_data = 32'h11223344; res_carry = 1'b1; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    chk("t4_b0", {24'h0, txa.tx_data}, 32'h44);
    step();
    chk("t4_b1", {24'h0, txa.tx_data}, 32'h33);
    res_valid = 1'b1; res_data = 32'hDEADBEEF;
    step();
    res_valid = 1'b0;
    chk("t4_ovr_set", {31'h0, overrun}, 32'h1);
    chk("t4_b2", {24'h0, txa.tx_data}, 32'h22);
    step();
    chk("t4_b3", {24'h0, txa.tx_data}, 32'h11);
    step();
    chk("t4_stat", {24'h0, txa.tx_data}, 32'h01);
    step();
    chk("t4_fd", {31'h0, frame_done}, 32'h1);
    chk("t4_ovr_hold", {31'h0, overrun}, 32'h1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("t4_ovr_clr", {31'h0, overrun}, 32'h0);
    chk("t4_no_frame", {31'h0, busy}, 32'h0);

    // Set beats clear; a rise on the final acceptance edge is also dropped
    res_data = 32'h01020304; res_carry = 1'b0; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    chk("t5_b0", {24'h0, txa.tx_data}, 32'h04);
    step();
    res_valid = 1'b1; clr_ovr = 1'b1;
    step();
    res_valid = 1'b0;
    chk("t5_set_wins", {31'h0, overrun}, 32'h1);
    chk("t5_b2", {24'h0, txa.tx_data}, 32'h02);
    step();
    clr_ovr = 1'b0;
    chk("t5_cleared", {31'h0, overrun}, 32'h0);
    chk("t5_b3", {24'h0, txa.tx_data}, 32'h01);
    step();
    chk("t5_stat", {24'h0, txa.tx_data}, 32'h00);
    chk("t5_stat_valid", {31'h0, txa.tx_valid}, 32'h1);
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    chk("t5_fd", {31'h0, frame_done}, 32'h1);
    chk("t5_last_ovr", {31'h0, overrun}, 32'h1);
    chk("t5_dropped_valid", {31'h0, txa.tx_valid}, 32'h0);
    step();
    chk("t5_dropped_busy", {31'h0, busy}, 32'h0);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("t5_ovr_clr", {31'h0, overrun}, 32'h0);

    // 16-bit framer without status byte
    res_data_b = 16'hA5C3; res_valid_b = 1'b1;
    step();
    res_valid_b = 1'b0;
    chk("b_b0", {24'h0, txb.tx_data}, 32'hC3);
    chk("b_valid0", {31'h0, txb.tx_valid}, 32'h1);
    step();
    chk("b_b1", {24'h0, txb.tx_data}, 32'hA5);
    chk("b_fd_early", {31'h0, frame_done_b}, 32'h0);
    step();
    chk("b_fd", {31'h0, frame_done_b}, 32'h1);
    chk("b_valid_off", {31'h0, txb.tx_valid}, 32'h0);
    chk("b_busy_off", {31'h0, busy_b}, 32'h0);

    // Reset mid-frame, then a still-high res_valid restarts from byte 0
    res_data = 32'h55667788; res_carry = 1'b0; res_valid = 1'b1;
    step();
    chk("t6_b0", {24'h0, txa.tx_data}, 32'h88);
    step();
    step();
    chk("t6_b2", {24'h0, txa.tx_data}, 32'h66);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_valid", {31'h0, txa.tx_valid}, 32'h0);
    chk("t6_rst_busy", {31'h0, busy}, 32'h0);
    chk("t6_rst_data", {24'h0, txa.tx_data}, 32'h0);
    step();
    chk("t6_restart_b0", {24'h0, txa.tx_data}, 32'h88);
    chk("t6_restart_busy", {31'h0, busy}, 32'h1);
    step();
    chk("t6_restart_b1", {24'h0, txa.tx_data}, 32'h77);
    res_valid = 1'b0;
    for (int c = 0; c < 6; c++) step();
    chk("t6_idle", {31'h0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_framer.md
Name: alu_result_framer

Overview:
- Downstream stage of the ALU arithmetic unit.
- Captures one arithmetic result (result word plus carry) on each new assertion of the ALU's valid flag.
- Serializes the result into a byte stream, LSB byte first, optionally followed by a status byte.
- Drives the TX byte path through a valid/ready handshake and reports results dropped while busy.

Parameters:
- RES_WIDTH, 32, result word width; must be a multiple of 8 and at least 8.
- SEND_STATUS, 1, when 1 a status byte {7'b0, carry} follows the data bytes; when 0 it is omitted.
- NBYTES, RES_WIDTH/8, derived localparam: data bytes per frame.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- res_data  in  RES_WIDTH  result word from the arithmetic unit.
- res_carry  in  1  carry/borrow from the arithmetic unit.
- res_valid  in  1  arithmetic flag; level signal, may stay high for many cycles.
- clr_ovr  in  1  clears the sticky overrun flag.
- tx_data  out  8  current byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  consumer accepts the byte.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse when the last byte of a frame is accepted.
- overrun  out  1  sticky; a result was dropped.

Behaviour:
- Reset (rst=1 at a clk edge):
  - tx_data=0, tx_valid=0, busy=0, frame_done=0, overrun=0.
  - State=IDLE, byte counter=0, capture register=0, res_valid delay register=0.
  - Reset mid-frame abandons the frame; no further bytes are sent.
- Trigger: rise = res_valid & ~res_valid_q. res_valid_q is updated every cycle.
  - A res_valid already high on the first cycle after reset counts as a rise.
  - A held-high res_valid yields exactly one frame.
- States: IDLE, DATA, STAT.
  - IDLE:
    - On rise: capture res_data and res_carry, load byte 0 (res_data[7:0]) into tx_data, set tx_valid=1, set counter=0, go to DATA.
    - Latency: rise in cycle N gives tx_valid=1 in cycle N+1.
  - DATA:
    - tx_data and tx_valid hold stable until tx_valid & tx_ready.
    - On transfer with counter < NBYTES-1: increment counter and present the next byte (capture[8k+7:8k]) in the next cycle. tx_valid stays high, so there is no bubble and back-to-back transfers give 1 byte per cycle.
    - On transfer of byte NBYTES-1:
      - If SEND_STATUS=1: present {7'b0, carry} and go to STAT.
      - Otherwise: tx_valid=0, frame_done=1 for one cycle, go to IDLE.
  - STAT:
    - On transfer: tx_valid=0, frame_done=1 for one cycle, go to IDLE.
- tx_ready while tx_valid=0 is ignored.
- Overrun:
  - A rise while state != IDLE sets overrun=1, and that result is dropped. This includes the cycle in which the final byte is accepted.
  - clr_ovr=1 clears overrun next cycle.
  - Simultaneous clr_ovr and a new overrun event leaves overrun=1 (set wins).
- The capture register is written only in IDLE on rise, so upstream changes to res_data mid-frame never corrupt the frame.
- busy = (state != IDLE), registered-state based; no combinational path from tx_ready to busy.
- tx_data is 0 whenever tx_valid=0.

Decomposition:
- Package alu_frame_pkg:
  - State enum (IDLE, DATA, STAT).
  - STAT_CARRY_BIT=0 and status byte layout constant.
  - BYTE_W=8.
- Counter width is $clog2(NBYTES) with a minimum of 1.
- No sub-module required. The rise detector stays inline, as a single flop plus AND.

Test Plan:
- rst, then res_valid rises with res_data=32'h11223344, res_carry=1, tx_ready tied 1 -> tx_data 44,33,22,11,01 on consecutive cycles starting N+1; frame_done in the cycle 01 is accepted; busy falls the next cycle.
- Same frame with tx_ready toggling 1,0,0,1,... -> each byte held stable while tx_ready=0; no byte skipped or duplicated; 5 transfers total.
- res_valid held high for 20 cycles, tx_ready=1 -> exactly one frame; overrun stays 0.
- Second res_valid rise while in DATA (res_data=32'hDEADBEEF) -> overrun=1, first frame's bytes unchanged; clr_ovr pulse -> overrun=0 next cycle.
- SEND_STATUS=0, RES_WIDTH=16, res_data=16'hA5C3 -> bytes C3,A5 only; frame_done on A5 transfer.
- rst asserted after 2 bytes sent -> tx_valid=0 and busy=0 next cycle; res_valid still high afterwards -> a new full frame starts with byte 0.
